fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that directly feeds instruction_reg.
- Holds the program counter and issues one-outstanding-request reads to instruction memory.
- Buffers returned 16-bit instructions in a 2-entry prefetch queue, presented downstream with a valid/ready handshake.
- Redirects the PC on jump or taken branch, and flushes queued and in-flight fetches.

Parameters:
- PC_W, 8, program counter / instruction memory word-address width
- INST_W, 16, instruction width
- RESET_PC, 8'h00, PC value loaded on reset
- DEPTH, 2, prefetch queue entries (power of two; verified at 2)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- jump_i  in  1  absolute redirect request from decode
- jump_target_i  in  PC_W  jump target (decode's imm field)
- branch_i  in  1  taken-branch redirect request
- branch_pc_i  in  PC_W  PC of the branch instruction
- displacement_i  in  8  signed branch displacement
- imem_req_o  out  1  memory read request, held until acked
- imem_addr_o  out  PC_W  read address, stable while imem_req_o=1
- imem_ack_i  in  1  read data valid this cycle
- imem_data_i  in  INST_W  read data
- inst_o  out  INST_W  head-of-queue instruction
- pc_o  out  PC_W  PC of inst_o
- valid_o  out  1  queue non-empty
- ready_i  in  1  downstream accepts inst_o when valid_o & ready_i

Behaviour:
- Reset (rst_i=1 at clock edge): fetch_pc=RESET_PC; queue empty; state=IDLE. Outputs are 0 (imem_req_o, valid_o, inst_o, pc_o), imem_addr_o=RESET_PC. Reset overrides all other inputs, including mid-transaction; a later stale ack is ignored because state is IDLE.
- FSM states:
  - IDLE: imem_req_o=0. Enters WAIT when queue occupancy + 0 in-flight < DEPTH, i.e. a free slot exists counting the slot reserved for the request.
  - WAIT: imem_req_o=1, imem_addr_o=fetch_pc. On imem_ack_i: push {imem_data_i, fetch_pc}, fetch_pc+=1 (wraps 8'hFF->8'h00). Next state is WAIT if a slot remains after this push and any same-cycle pop, else IDLE.
  - DISCARD: imem_req_o=1, imem_addr_o=stale address held. The in-flight ack is dropped, not pushed. On ack go to WAIT at the redirected fetch_pc.
- Request issue: imem_req_o is registered. The earliest request is 1 cycle after reset release. Back-to-back acks give 1 instruction/cycle throughput.
- Queue: FIFO of {inst, pc}. inst_o/pc_o show the head combinationally from storage, or 0 when empty. Pop on valid_o & ready_i. Simultaneous push and pop are both honoured; occupancy is unchanged.
- Redirect: redirect = jump_i | branch_i.
  - jump_i has priority if both are asserted.
  - Jump target = jump_target_i.
  - Branch target = branch_pc_i + 1 + sign_extend(displacement_i), computed modulo 2^PC_W.
  - Same cycle: queue flushed (any same-cycle pop still counts as accepted; push suppressed). fetch_pc := target.
  - WAIT with no ack that cycle -> DISCARD. WAIT with ack that cycle -> data dropped, go to WAIT with new PC. IDLE -> WAIT.
  - Redirect during DISCARD updates fetch_pc and stays in DISCARD.
- valid_o is low the cycle after a redirect; the first redirected instruction appears 1 cycle after its ack.
- No combinational path from imem_ack_i/imem_data_i to imem_req_o. valid_o, inst_o and pc_o depend only on registered state.

Test Plan:
- Reset release, memory acks every request 1 cycle later (mem[a]=16'hA000+a), ready_i=1 -> addresses 00,01,02… requested. inst_o sequence A000, A001, A002 with pc_o 00, 01, 02; one instruction per cycle steady-state.
- ready_i=0 continuously -> exactly 2 instructions (pc 00, 01) buffered, imem_req_o drops to 0. ready_i=1 one cycle -> head pops, one new request to addr 02.
- Branch at pc_o=05, displacement_i=8'hFC -> next valid instruction has pc_o=02. With displacement_i=8'h7F from pc 8'hF0 -> target wraps to 8'h70.
- Jump to 8'h40 asserted while a request to 03 is outstanding with ack delayed 3 cycles -> the ack for 03 is discarded, next request addr 40, first valid inst_o=mem[40].
- jump_i (target 10) and branch_i (pc 20, disp 04) asserted in the same cycle as an ack -> acked data dropped, next fetch addr 10.
- rst_i asserted for 1 cycle while in WAIT, stale ack arrives the following cycle -> ack ignored, valid_o=0, next request addr 00.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem reads,
// small prefetch queue, and jump/branch redirect with flush.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INST_W   = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              jump_i,
    input  logic [PC_W-1:0]   jump_target_i,
    input  logic              branch_i,
    input  logic [PC_W-1:0]   branch_pc_i,
    input  logic [7:0]        displacement_i,
    output logic              imem_req_o,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_data_i,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              valid_o,
    input  logic              ready_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_fetch_pc;
    logic              r_req;
    logic [PC_W-1:0]   r_addr;

    logic [INST_W-1:0] r_q_inst [DEPTH];
    logic [PC_W-1:0]   r_q_pc   [DEPTH];
    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_count;

    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic              w_redirect;
    logic [PC_W-1:0]   w_br_target;
    logic [PC_W-1:0]   w_target;
    logic [PC_W-1:0]   w_pc_inc;
    logic [CNT_W-1:0]  w_cnt_next;

    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid & ready_i;
    assign w_redirect  = jump_i | branch_i;
    assign w_br_target = branch_pc_i + PC_W'(1)
                       + PC_W'($signed(displacement_i));
    assign w_target    = jump_i ? jump_target_i : w_br_target;
    assign w_pc_inc    = r_fetch_pc + PC_W'(1);
    // Only a WAIT-state ack carries live data; redirect drops it.
    assign w_push      = imem_ack_i & (r_state == S_WAIT) & ~w_redirect;
    assign w_cnt_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    assign imem_req_o  = r_req;
    assign imem_addr_o = r_addr;
    assign valid_o     = w_valid;
    assign inst_o      = w_valid ? r_q_inst[r_rd] : '0;
    assign pc_o        = w_valid ? r_q_pc[r_rd]   : '0;

    // Fetch FSM: PC, request strobe and held request address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_redirect) begin
                        r_fetch_pc <= w_target;
                        r_addr     <= w_target;
                        r_req      <= 1'b1;
                        r_state    <= S_WAIT;
                    end else if (r_count < DEPTH_C) begin
                        r_addr     <= r_fetch_pc;
                        r_req      <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_redirect) begin
                        r_fetch_pc <= w_target;
                        if (imem_ack_i) begin
                            r_addr  <= w_target;
                            r_state <= S_WAIT;
                        end else begin
                            r_state <= S_DISCARD;
                        end
                    end else if (imem_ack_i) begin
                        r_fetch_pc <= w_pc_inc;
                        r_addr     <= w_pc_inc;
                        if (w_cnt_next < DEPTH_C) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_req   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DISCARD: begin
                    if (w_redirect) begin
                        r_fetch_pc <= w_target;
                    end
                    if (imem_ack_i) begin
                        r_addr  <= w_redirect ? w_target : r_fetch_pc;
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Prefetch queue: push acked data, pop on handshake, flush on redirect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (w_redirect) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_q_inst[r_wr] <= imem_data_i;
                r_q_pc[r_wr]   <= r_fetch_pc;
                r_wr           <= r_wr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            r_count <= w_cnt_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple imem responder
// returning 16'hA000 + addr after a programmable delay.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        jump_i;
    logic [7:0]  jump_target_i;
    logic        branch_i;
    logic [7:0]  branch_pc_i;
    logic [7:0]  displacement_i;
    logic        imem_req_o;
    logic [7:0]  imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [15:0] imem_data_i = 16'h0;
    logic [15:0] inst_o;
    logic [7:0]  pc_o;
    logic        valid_o;
    logic        ready_i;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_delay = 0;
    int stale_req = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .branch_i       (branch_i),
        .branch_pc_i    (branch_pc_i),
        .displacement_i (displacement_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_data_i    (imem_data_i),
        .inst_o         (inst_o),
        .pc_o           (pc_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i)
    );

    // Memory responder; a stale-ack request injects one ack
    // regardless of the DUT request line.
    initial begin
        int wcnt;
        int stale_done;
        wcnt = 0;
        stale_done = 0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack_i  = 1'b0;
            imem_data_i = 16'h0;
            if (stale_req != stale_done) begin
                stale_done  = stale_done + 1;
                imem_ack_i  = 1'b1;
                imem_data_i = 16'hDEAD;
                wcnt        = 0;
            end else if (imem_req_o) begin
                if (wcnt >= ack_delay) begin
                    imem_ack_i  = 1'b1;
                    imem_data_i = 16'hA000 + 16'(imem_addr_o);
                    wcnt        = 0;
                end else begin
                    wcnt = wcnt + 1;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic wait_pc(input logic [7:0] val, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (valid_o && pc_o == val) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, 32'(found), 32'h1);
    endtask

    task automatic wait_addr(input logic [7:0] val, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (imem_req_o && imem_addr_o == val) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, 32'(found), 32'h1);
    endtask

    task automatic wait_valid(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (valid_o) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, 32'(found), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_i          = 1'b1;
        jump_i         = 1'b0;
        jump_target_i  = 8'h00;
        branch_i       = 1'b0;
        branch_pc_i    = 8'h00;
        displacement_i = 8'h00;
        ready_i        = 1'b1;

        // Reset state, then streaming at one instruction per cycle.
        @(posedge clk);
        @(negedge clk);
        chk("rst_req",   32'(imem_req_o),  32'h0);
        chk("rst_valid", 32'(valid_o),     32'h0);
        chk("rst_inst",  32'(inst_o),      32'h0);
        chk("rst_pc",    32'(pc_o),        32'h0);
        chk("rst_addr",  32'(imem_addr_o), 32'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("idle_req", 32'(imem_req_o), 32'h0);
        @(negedge clk);
        chk("t1_req",   32'(imem_req_o),  32'h1);
        chk("t1_addr",  32'(imem_addr_o), 32'h0);
        chk("t1_valid0", 32'(valid_o),    32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_valid", 32'(valid_o), 32'h1);
            chk("t1_inst",  32'(inst_o),  32'hA000 + 32'(k));
            chk("t1_pc",    32'(pc_o),    32'(k));
        end

        // Backpressure: two entries buffered, request stops.
        ready_i = 1'b0;
        do_reset();
        repeat (6) @(negedge clk);
        chk("bp_valid", 32'(valid_o),    32'h1);
        chk("bp_inst",  32'(inst_o),     32'hA000);
        chk("bp_pc",    32'(pc_o),       32'h0);
        chk("bp_req",   32'(imem_req_o), 32'h0);
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        @(negedge clk);
        chk("bp_pop_pc",   32'(pc_o),       32'h1);
        chk("bp_pop_inst", 32'(inst_o),     32'hA001);
        chk("bp_pop_req",  32'(imem_req_o), 32'h0);
        @(negedge clk);
        chk("bp_rq_req",  32'(imem_req_o),  32'h1);
        chk("bp_rq_addr", 32'(imem_addr_o), 32'h2);
        @(negedge clk);
        chk("bp_full_req", 32'(imem_req_o), 32'h0);
        chk("bp_full_pc",  32'(pc_o),       32'h1);

        // Backward branch from 05, then wrapping forward branch.
        ready_i = 1'b1;
        do_reset();
        wait_pc(8'h05, "br_wait5");
        branch_i       = 1'b1;
        branch_pc_i    = 8'h05;
        displacement_i = 8'hFC;
        @(posedge clk);
        #1;
        branch_i = 1'b0;
        @(negedge clk);
        chk("br_flush", 32'(valid_o),     32'h0);
        chk("br_addr",  32'(imem_addr_o), 32'h2);
        chk("br_req",   32'(imem_req_o),  32'h1);
        @(negedge clk);
        chk("br_valid", 32'(valid_o), 32'h1);
        chk("br_pc",    32'(pc_o),    32'h2);
        chk("br_inst",  32'(inst_o),  32'hA002);
        branch_i       = 1'b1;
        branch_pc_i    = 8'hF0;
        displacement_i = 8'h7F;
        @(posedge clk);
        #1;
        branch_i = 1'b0;
        @(negedge clk);
        chk("brw_flush", 32'(valid_o), 32'h0);
        @(negedge clk);
        chk("brw_valid", 32'(valid_o), 32'h1);
        chk("brw_pc",    32'(pc_o),    32'h70);
        chk("brw_inst",  32'(inst_o),  32'hA070);

        // Jump while a slow request to 03 is outstanding.
        ack_delay = 3;
        do_reset();
        wait_addr(8'h03, "jmp_wait3");
        jump_i        = 1'b1;
        jump_target_i = 8'h40;
        @(posedge clk);
        #1;
        jump_i = 1'b0;
        @(negedge clk);
        chk("jmp_hold_req",  32'(imem_req_o),  32'h1);
        chk("jmp_hold_addr", 32'(imem_addr_o), 32'h3);
        chk("jmp_flush",     32'(valid_o),     32'h0);
        wait_addr(8'h40, "jmp_wait40");
        wait_valid("jmp_wait_valid");
        chk("jmp_inst", 32'(inst_o), 32'hA040);
        chk("jmp_pc",   32'(pc_o),   32'h40);

        // Jump and branch together with an ack: jump wins, data dropped.
        ack_delay = 0;
        do_reset();
        wait_pc(8'h03, "jb_wait3");
        jump_i         = 1'b1;
        jump_target_i  = 8'h10;
        branch_i       = 1'b1;
        branch_pc_i    = 8'h20;
        displacement_i = 8'h04;
        @(posedge clk);
        #1;
        jump_i   = 1'b0;
        branch_i = 1'b0;
        @(negedge clk);
        chk("jb_flush", 32'(valid_o),     32'h0);
        chk("jb_addr",  32'(imem_addr_o), 32'h10);
        chk("jb_req",   32'(imem_req_o),  32'h1);
        @(negedge clk);
        chk("jb_valid", 32'(valid_o), 32'h1);
        chk("jb_pc",    32'(pc_o),    32'h10);
        chk("jb_inst",  32'(inst_o),  32'hA010);

        // Reset in WAIT followed by a stale ack.
        do_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rw_req",  32'(imem_req_o),  32'h1);
        chk("rw_addr", 32'(imem_addr_o), 32'h0);
        rst_i     = 1'b1;
        stale_req = stale_req + 1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rw_rst_req",   32'(imem_req_o), 32'h0);
        chk("rw_rst_valid", 32'(valid_o),    32'h0);
        @(negedge clk);
        chk("rw_stale_valid", 32'(valid_o),     32'h0);
        chk("rw_re_req",      32'(imem_req_o),  32'h1);
        chk("rw_re_addr",     32'(imem_addr_o), 32'h0);
        @(negedge clk);
        chk("rw_valid", 32'(valid_o), 32'h1);
        chk("rw_inst",  32'(inst_o),  32'hA000);
        chk("rw_pc",    32'(pc_o),    32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
